// File: rtl/jtkcpu_idx_seq.sv
// Indexed-addressing postbyte sequencer: reads offset/pointer bytes and issues address-generator strobes.
// Optional indirect support is enabled by defining JTKCPU_IDX_INDIRECT_EN.
module jtkcpu_idx_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [7:0]  postbyte,
  output logic        busy,
  output logic        rd_req,
  output logic        rd_ptr,
  output logic        rd_hi,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [15:0] mdata,
  output logic [2:0]  reg_sel,
  output logic [1:0]  racc_sel,
  output logic        idx_8,
  output logic        idx_16,
  output logic        idx_acc,
  output logic        idx_ld,
  output logic        idx_dp,
  output logic        data2addr,
  output logic        reg_upd,
  output logic        reg_dec,
  output logic        reg_two,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PRE    = 4'd1;
  localparam logic [3:0] S_EXT_HI = 4'd2;
  localparam logic [3:0] S_EXT_LO = 4'd3;
  localparam logic [3:0] S_CALC   = 4'd4;
  localparam logic [3:0] S_POST   = 4'd5;
  localparam logic [3:0] S_FIN    = 4'd6;
`ifdef JTKCPU_IDX_INDIRECT_EN
  localparam logic [3:0] S_IND_HI = 4'd7;
  localparam logic [3:0] S_IND_LO = 4'd8;
  localparam logic [3:0] S_PTR    = 4'd9;
`endif

  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic [6:0]  r_post;
  logic [15:0] r_mdata;
  logic        r_err;
  logic [3:0]  w_mode;
  logic [3:0]  w_in_mode;
  logic [2:0]  w_in_reg;
  logic        w_illegal;
  logic [3:0]  w_after;
  logic        w_calc;

  assign w_mode    = r_post[3:0];
  assign w_in_mode = postbyte[3:0];
  assign w_in_reg  = postbyte[6:4];

  // Auto inc/dec of PC makes no sense, so those combinations are rejected too.
`ifdef JTKCPU_IDX_INDIRECT_EN
  logic r_ind;
  assign w_illegal = (w_in_reg > 3'd4) || (w_in_mode >= 4'hC) ||
                     ((w_in_reg == 3'd4) && (w_in_mode >= 4'd1) && (w_in_mode <= 4'd4));
  assign w_after   = r_ind ? S_IND_HI : S_FIN;
`else
  assign w_illegal = postbyte[7] || (w_in_reg > 3'd4) || (w_in_mode >= 4'hC) ||
                     ((w_in_reg == 3'd4) && (w_in_mode >= 4'd1) && (w_in_mode <= 4'd4));
  assign w_after   = S_FIN;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_illegal) w_next = S_FIN;
          else begin
            case (w_in_mode)
              4'd3, 4'd4: w_next = S_PRE;
              4'd6, 4'hB: w_next = S_EXT_HI;
              4'd5, 4'hA: w_next = S_EXT_LO;
              default:    w_next = S_CALC;
            endcase
          end
        end
      end
      S_PRE:    w_next = S_CALC;
      S_EXT_HI: if (rd_ack) w_next = S_EXT_LO;
      S_EXT_LO: if (rd_ack) w_next = S_CALC;
      S_CALC:   w_next = ((w_mode == 4'd1) || (w_mode == 4'd2)) ? S_POST : w_after;
      S_POST:   w_next = w_after;
`ifdef JTKCPU_IDX_INDIRECT_EN
      S_IND_HI: if (rd_ack) w_next = S_IND_LO;
      S_IND_LO: if (rd_ack) w_next = S_PTR;
      S_PTR:    w_next = S_FIN;
`endif
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_post  <= 7'd0;
      r_mdata <= 16'd0;
      r_err   <= 1'b0;
`ifdef JTKCPU_IDX_INDIRECT_EN
      r_ind   <= 1'b0;
`endif
    end else if (cen) begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start) begin
        r_post  <= postbyte[6:0];
        r_mdata <= 16'd0;
        r_err   <= w_illegal;
`ifdef JTKCPU_IDX_INDIRECT_EN
        r_ind   <= postbyte[7];
`endif
      end else if (r_state == S_FIN) begin
        r_err <= 1'b0;
      end
      // Reads complete only in a requesting state; stray acks fall through.
      if (rd_ack) begin
        case (r_state)
          S_EXT_HI: r_mdata[15:8] <= rd_data;
          S_EXT_LO: r_mdata[7:0]  <= rd_data;
`ifdef JTKCPU_IDX_INDIRECT_EN
          S_IND_HI: r_mdata[15:8] <= rd_data;
          S_IND_LO: r_mdata[7:0]  <= rd_data;
`endif
          default: ;
        endcase
      end
    end
  end

  assign w_calc  = cen && (r_state == S_CALC);
  assign busy    = (r_state != S_IDLE);
  assign mdata   = r_mdata;
  assign reg_sel = r_post[6:4];

`ifdef JTKCPU_IDX_INDIRECT_EN
  assign rd_req    = (r_state == S_EXT_HI) || (r_state == S_EXT_LO) ||
                     (r_state == S_IND_HI) || (r_state == S_IND_LO);
  assign rd_ptr    = (r_state == S_IND_HI) || (r_state == S_IND_LO);
  assign rd_hi     = (r_state == S_IND_LO);
  assign data2addr = (w_calc && (w_mode == 4'hB)) || (cen && (r_state == S_PTR));
`else
  assign rd_req    = (r_state == S_EXT_HI) || (r_state == S_EXT_LO);
  assign rd_ptr    = 1'b0;
  assign rd_hi     = 1'b0;
  assign data2addr = w_calc && (w_mode == 4'hB);
`endif

  always_comb begin
    racc_sel = 2'd0;
    if (r_state == S_CALC) begin
      case (w_mode)
        4'd8:    racc_sel = 2'd1;
        4'd9:    racc_sel = 2'd2;
        default: racc_sel = 2'd0;
      endcase
    end
  end

  assign idx_ld  = w_calc && (w_mode <= 4'd4);
  assign idx_8   = w_calc && (w_mode == 4'd5);
  assign idx_16  = w_calc && (w_mode == 4'd6);
  assign idx_acc = w_calc && (w_mode >= 4'd7) && (w_mode <= 4'd9);
  assign idx_dp  = w_calc && (w_mode == 4'hA);
  assign reg_upd = cen && ((r_state == S_PRE) || (r_state == S_POST));
  assign reg_dec = cen && (r_state == S_PRE);
  assign reg_two = cen && (((r_state == S_PRE) && (w_mode == 4'd4)) ||
                           ((r_state == S_POST) && (w_mode == 4'd2)));
  assign done    = cen && (r_state == S_FIN);
  assign err     = done && r_err;

endmodule

// File: tb/tb_jtkcpu_idx_seq.sv
// Directed cycle-by-cycle bench for jtkcpu_idx_seq; every check goes through chk().
module tb_jtkcpu_idx_seq;
  logic        clk = 1'b0;
  logic        rst, cen, start, rd_ack;
  logic [7:0]  postbyte, rd_data;
  logic        busy, rd_req, rd_ptr, rd_hi;
  logic [15:0] mdata;
  logic [2:0]  reg_sel;
  logic [1:0]  racc_sel;
  logic        idx_8, idx_16, idx_acc, idx_ld, idx_dp, data2addr;
  logic        reg_upd, reg_dec, reg_two, done, err;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam int BUSY = 1 << 14, RQ  = 1 << 13, PTR = 1 << 12, HI  = 1 << 11;
  localparam int I8   = 1 << 10, I16 = 1 << 9,  ACC = 1 << 8,  LD  = 1 << 7;
  localparam int DP   = 1 << 6,  D2A = 1 << 5,  UPD = 1 << 4,  DEC = 1 << 3;
  localparam int TWO  = 1 << 2,  DN  = 1 << 1,  ER  = 1;
  localparam int RA1  = 1 << 15;

  logic [16:0] w_obs;
  assign w_obs = {racc_sel, busy, rd_req, rd_ptr, rd_hi, idx_8, idx_16, idx_acc, idx_ld,
                  idx_dp, data2addr, reg_upd, reg_dec, reg_two, done, err};

  always #5 clk = ~clk;

  jtkcpu_idx_seq dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .postbyte(postbyte),
    .busy(busy), .rd_req(rd_req), .rd_ptr(rd_ptr), .rd_hi(rd_hi),
    .rd_ack(rd_ack), .rd_data(rd_data), .mdata(mdata), .reg_sel(reg_sel),
    .racc_sel(racc_sel), .idx_8(idx_8), .idx_16(idx_16), .idx_acc(idx_acc),
    .idx_ld(idx_ld), .idx_dp(idx_dp), .data2addr(data2addr), .reg_upd(reg_upd),
    .reg_dec(reg_dec), .reg_two(reg_two), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check outputs at the falling edge, then move to just past the next rising edge.
  task automatic step(input string tag, input int exp, input int rs,
                      input bit md_en, input logic [15:0] md);
    @(negedge clk);
    chk({tag, "_out"}, {15'd0, w_obs}, exp);
    chk({tag, "_reg"}, {29'd0, reg_sel}, rs);
    if (md_en) chk({tag, "_md"}, {16'd0, mdata}, {16'd0, md});
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [7:0] pb);
    start = 1'b1; postbyte = pb;
    @(posedge clk); #1;
    start = 1'b0; postbyte = 8'h00;
  endtask

  logic [7:0] bad_pb [3] = '{8'h0D, 8'h41, 8'h50};
  logic [7:0] pb;

  initial begin
    rst = 1'b1; cen = 1'b0; start = 1'b0; postbyte = 8'h00; rd_ack = 1'b0; rd_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 0, 1'b1, 16'h0000);
    rst = 1'b0; cen = 1'b1;

    // n8,X with two wait states; a start while busy must be ignored
    launch(8'h05);
    step("a_w1", BUSY | RQ, 0, 1'b1, 16'h0000);
    start = 1'b1; postbyte = 8'h00;
    step("a_w2", BUSY | RQ, 0, 1'b0, 16'h0);
    start = 1'b0;
    rd_ack = 1'b1; rd_data = 8'hF0;
    step("a_ack", BUSY | RQ, 0, 1'b0, 16'h0);
    rd_ack = 1'b0;
    step("a_calc", BUSY | I8, 0, 1'b1, 16'h00F0);
    step("a_fin", BUSY | DN, 0, 1'b0, 16'h0);
    rd_ack = 1'b1; rd_data = 8'h55;
    step("stray_ack", 0, 0, 1'b1, 16'h00F0);
    rd_ack = 1'b0;
    step("stray_after", 0, 0, 1'b1, 16'h00F0);

    // ,Y++
    launch(8'h12);
    step("b_calc", BUSY | LD, 1, 1'b0, 16'h0);
    step("b_post", BUSY | UPD | TWO, 1, 1'b0, 16'h0);
    step("b_fin", BUSY | DN, 1, 1'b0, 16'h0);
    step("b_idle", 0, 1, 1'b0, 16'h0);

    // ,--U
    launch(8'h24);
    step("c_pre", BUSY | UPD | DEC | TWO, 2, 1'b0, 16'h0);
    step("c_calc", BUSY | LD, 2, 1'b0, 16'h0);
    step("c_fin", BUSY | DN, 2, 1'b0, 16'h0);

    // ,X+ with a clock-enable stall in CALC
    launch(8'h01);
    cen = 1'b0;
    step("g_stall", BUSY, 0, 1'b0, 16'h0);
    cen = 1'b1;
    step("g_calc", BUSY | LD, 0, 1'b0, 16'h0);
    step("g_post", BUSY | UPD, 0, 1'b0, 16'h0);
    step("g_fin", BUSY | DN, 0, 1'b0, 16'h0);

    // B,S
    launch(8'h38);
    step("r_calc", BUSY | ACC | RA1, 3, 1'b0, 16'h0);
    step("r_fin", BUSY | DN, 3, 1'b0, 16'h0);

    // [n16,X]
    launch(8'h86);
`ifdef JTKCPU_IDX_INDIRECT_EN
    rd_ack = 1'b1; rd_data = 8'h12;
    step("d_exthi", BUSY | RQ, 0, 1'b0, 16'h0);
    rd_data = 8'h34;
    step("d_extlo", BUSY | RQ, 0, 1'b0, 16'h0);
    rd_ack = 1'b0;
    step("d_calc", BUSY | I16, 0, 1'b1, 16'h1234);
    rd_ack = 1'b1; rd_data = 8'hAB;
    step("d_indhi", BUSY | RQ | PTR, 0, 1'b1, 16'h1234);
    rd_data = 8'hCD;
    step("d_indlo", BUSY | RQ | PTR | HI, 0, 1'b0, 16'h0);
    rd_ack = 1'b0;
    step("d_ptr", BUSY | D2A, 0, 1'b1, 16'hABCD);
    step("d_fin", BUSY | DN, 0, 1'b0, 16'h0);
`else
    step("d_err", BUSY | DN | ER, 0, 1'b0, 16'h0);
`endif
    step("d_idle", 0, 0, 1'b0, 16'h0);

    // illegal mode, PC auto-increment, illegal register
    for (int i = 0; i < 3; i++) begin
      pb = bad_pb[i];
      launch(pb);
      step("e_err", BUSY | DN | ER, {29'd0, pb[6:4]}, 1'b1, 16'h0000);
      step("e_idle", 0, {29'd0, pb[6:4]}, 1'b0, 16'h0);
    end

    // reset while waiting in EXT_LO, then a fresh decode
    launch(8'h1A);
    step("f_wait", BUSY | RQ, 1, 1'b0, 16'h0);
    rst = 1'b1;
    step("f_rst", BUSY | RQ, 1, 1'b0, 16'h0);
    rst = 1'b0;
    step("f_after", 0, 0, 1'b1, 16'h0000);
    step("f_quiet", 0, 0, 1'b0, 16'h0);
    launch(8'h00);
    step("f_calc", BUSY | LD, 0, 1'b0, 16'h0);
    step("f_fin", BUSY | DN, 0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/jtkcpu_idx_seq.md
JTKCPU_IDX_SEQ -- requirements
Module: jtkcpu_idx_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the only clock.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port cen, input, 1 bit: clock enable; all state and outputs advance only when cen=1.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle request to decode postbyte; honoured only when busy=0.
REQ-005 The block SHALL have port postbyte, input, 8 bits: indexed-mode postbyte, sampled with start.
REQ-006 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-007 The block SHALL have port rd_req, output, 1 bit: byte read request, held until rd_ack.
REQ-008 The block SHALL have port rd_ptr, output, 1 bit: 0 = read next stream byte at PC; 1 = read at the computed address.
REQ-009 The block SHALL have port rd_hi, output, 1 bit: with rd_ptr=1, selects computed address +1.
REQ-010 The block SHALL have ports rd_ack, input, 1 bit, and rd_data, input, 8 bits: read completion and data, valid together.
REQ-011 The block SHALL have port mdata, output, 16 bits: assembled offset, direct byte, or pointer for the address generator.
REQ-012 The block SHALL have port reg_sel, output, 3 bits: 0 X, 1 Y, 2 U, 3 S, 4 PC.
REQ-013 The block SHALL have port racc_sel, output, 2 bits: 0 A, 1 B, 2 D.
REQ-014 The block SHALL have ports idx_8, idx_16, idx_acc, idx_ld, idx_dp and data2addr, each an output of 1 bit: one-cycle address-generator strobes.
REQ-015 The block SHALL have ports reg_upd, reg_dec and reg_two, each an output of 1 bit: index register writeback strobe, decrement, and step of 2 (else 1).
REQ-016 The block SHALL have ports done and err, each an output of 1 bit: one-cycle completion pulse and illegal-postbyte pulse.

Function
REQ-017 The postbyte SHALL decode as: bit7 = indirect; bits6:4 = reg_sel, where values 5-7 are illegal; bits3:0 = mode.
REQ-018 Modes SHALL be: 0 ,R; 1 ,R+; 2 ,R++; 3 ,-R; 4 ,--R; 5 n8,R; 6 n16,R; 7 A,R; 8 B,R; 9 D,R; A direct; B extended; C-F illegal.
REQ-019 The states SHALL be IDLE, PRE, EXT_HI, EXT_LO, CALC, POST, IND_HI, IND_LO, PTR and FIN.
REQ-020 IDLE: on start, the block SHALL latch the postbyte and go to PRE for modes 3/4, to EXT_HI for modes 6/B, to EXT_LO for modes 5/A, and to CALC otherwise.
REQ-021 PRE SHALL pulse reg_upd=1 and reg_dec=1, with reg_two=1 for mode 4, then go to CALC.
REQ-022 EXT_HI/EXT_LO SHALL fetch with rd_ptr=0, load rd_data into mdata[15:8]/mdata[7:0], and stay in the state while rd_ack=0.
REQ-023 CALC SHALL pulse exactly one strobe: idx_ld (modes 0-4), idx_8 (5), idx_16 (6), idx_acc with racc_sel 0/1/2 (7/8/9), idx_dp (A), data2addr (B).
REQ-024 After CALC the next state SHALL be POST for modes 1/2, else IND_HI if indirect, else FIN.
REQ-025 POST SHALL pulse reg_upd=1 with reg_dec=0 and reg_two set for mode 2, then go to IND_HI if indirect, else FIN.
REQ-026 IND_HI/IND_LO SHALL read with rd_ptr=1 and rd_hi=0/1, load mdata[15:8]/[7:0], then go to PTR.
REQ-027 PTR SHALL pulse data2addr with mdata equal to the pointer, then go to FIN.
REQ-028 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-029 Illegal reg_sel or mode SHALL pulse err and done together in the cycle after start, with no strobes, no reads and no writeback.
REQ-030 Modes 1-4 with reg_sel=4 (PC) SHALL be illegal.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 rd_ack without rd_req SHALL be ignored.
REQ-033 rd_req SHALL fall in the cycle after rd_ack.
REQ-034 With cen=0 the block SHALL hold all state, and strobes SHALL stay low.
REQ-035 mode 5 SHALL set mdata[15:8]=0, because the address generator performs sign extension.

Reset
REQ-036 While rst=1 at a clk edge, regardless of cen, the state SHALL become IDLE and every output, mdata and the latched postbyte SHALL become 0.
REQ-037 Reset mid-sequence SHALL abort the decode without done, err or writeback.

Configuration
REQ-038 With macro JTKCPU_IDX_INDIRECT_EN defined, bit7 SHALL follow REQ-024 to REQ-027.
REQ-039 With JTKCPU_IDX_INDIRECT_EN undefined, any postbyte with bit7=1 SHALL be illegal per REQ-029, and the IND_HI, IND_LO and PTR states SHALL be absent.

Verification
REQ-040 A bench SHALL cover: postbyte 0x05, rd_data 0xF0 after 2 wait cycles -> rd_ptr=0 request, mdata=0x00F0, one idx_8 pulse, done 1 cycle later.
REQ-041 A bench SHALL cover: postbyte 0x12 (,Y++) -> idx_ld, then reg_upd with reg_dec=0 and reg_two=1, then done; reg_sel=1 throughout.
REQ-042 A bench SHALL cover: postbyte 0x24 (,--U) -> reg_upd with reg_dec=1 and reg_two=1 one cycle before idx_ld.
REQ-043 A bench SHALL cover: postbyte 0x86 with ext 0x12,0x34, then pointer bytes 0xAB,0xCD -> idx_16 with mdata 0x1234, reads with rd_hi=0 then 1, data2addr with mdata 0xABCD, then done (macro defined); err=1 with the macro undefined.
REQ-044 A bench SHALL cover: postbyte 0x0D, 0x41 or 0x50 -> err and done in the next cycle, with no rd_req and no strobes.
REQ-045 A bench SHALL cover: rst asserted while waiting for rd_ack in EXT_LO -> all outputs 0 on the next edge, no done, and a new start accepted afterwards.
